// File: rtl/scic_pkg.sv
// Shared constants for the SCIC memory-mapped timer: register offsets,
// CTRL bit positions and the default window base address.
package scic_pkg;

    localparam logic [15:0] TMR_BASE     = 16'hFFF0;

    localparam logic [2:0]  TMR_CTRL     = 3'd0;
    localparam logic [2:0]  TMR_LOAD     = 3'd1;
    localparam logic [2:0]  TMR_COUNT    = 3'd2;
    localparam logic [2:0]  TMR_STATUS   = 3'd3;
    localparam logic [2:0]  TMR_PRESCALE = 3'd4;

    localparam int TMR_EN   = 0;
    localparam int TMR_AUTO = 1;
    localparam int TMR_IE   = 2;

    localparam int TMR_CTRL_W = 3;

endpackage

// File: rtl/scic_timer_if.sv
// CPU-side bus shared by SCIC responders: address/write data/we from the CPU,
// combinational hit/data_out back from the addressed responder.
interface scic_timer_if;
    // Single-cycle bus: a write commits on the rising edge where we=1 and
    // hit=1; read data is valid in the same cycle the address is presented.
    logic [15:0] address;
    logic [31:0] data_fromCPU;
    logic        we;
    logic [31:0] data_out;
    logic        hit;

    modport master (
        output address,
        output data_fromCPU,
        output we,
        input  data_out,
        input  hit
    );

    modport slave (
        input  address,
        input  data_fromCPU,
        input  we,
        output data_out,
        output hit
    );
endinterface

// File: rtl/scic_timer_prescaler.sv
// Free-running prescale counter: counts 0..limit while enabled and pulses
// tick on the cycle it sits at limit, then restarts from 0.
module scic_timer_prescaler (
    input  logic        clock,
    input  logic        reset,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [15:0] limit_i,
    output logic        tick_o
);

    logic [15:0] pcnt_q, pcnt_d;

    assign tick_o = en_i && (pcnt_q == limit_i);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = 16'd0;
        end else if (en_i) begin
            pcnt_d = tick_o ? 16'd0 : pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= 16'd0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/scic_timer.sv
// Memory-mapped interval timer: five-register window at BASE, prescaled
// 32-bit down counter with optional auto-reload and a level interrupt.
module scic_timer
    import scic_pkg::*;
#(
    parameter logic [15:0] BASE = TMR_BASE
) (
    input  logic         clock,
    input  logic         reset,
    scic_timer_if.slave  bus,
    output logic         irq
);

    logic [TMR_CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic [15:0]           prescale_q, prescale_d;
    logic                  expired_q, expired_d;
    logic                  irq_q, irq_d;

    logic [15:0] offset;
    logic [2:0]  sel;
    logic        hit;
    logic        wr, wr_ctrl, wr_load, wr_count, wr_status, wr_prescale;
    logic        tick, fire;

    // Offset is computed from a subtraction so the window never wraps past FFFF.
    assign offset = bus.address - BASE;
    assign sel    = offset[2:0];
    assign hit    = (bus.address >= BASE) && (offset <= 16'd4);

    assign wr          = bus.we && hit;
    assign wr_ctrl     = wr && (sel == TMR_CTRL);
    assign wr_load     = wr && (sel == TMR_LOAD);
    assign wr_count    = wr && (sel == TMR_COUNT);
    assign wr_status   = wr && (sel == TMR_STATUS);
    assign wr_prescale = wr && (sel == TMR_PRESCALE);

    scic_timer_prescaler u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .en_i    (ctrl_q[TMR_EN]),
        .clr_i   (wr_count),
        .limit_i (prescale_q),
        .tick_o  (tick)
    );

    // A CPU write to COUNT supersedes everything the tick would have done.
    assign fire = tick && !wr_count;

    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        expired_d  = expired_q;
        irq_d      = expired_q && ctrl_q[TMR_IE];

        if (wr_status && bus.data_fromCPU[0]) begin
            expired_d = 1'b0;
        end

        if (fire) begin
            if (count_q == 32'd0) begin
                expired_d = 1'b1;
                if (ctrl_q[TMR_AUTO]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[TMR_EN] = 1'b0;
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (wr_ctrl)     ctrl_d     = bus.data_fromCPU[TMR_CTRL_W-1:0];
        if (wr_load)     load_d     = bus.data_fromCPU;
        if (wr_count)    count_d    = bus.data_fromCPU;
        if (wr_prescale) prescale_d = bus.data_fromCPU[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q     <= '0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            prescale_q <= 16'd0;
            expired_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            expired_q  <= expired_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        bus.data_out = 32'd0;
        if (hit) begin
            case (sel)
                TMR_CTRL:     bus.data_out = {{(32-TMR_CTRL_W){1'b0}}, ctrl_q};
                TMR_LOAD:     bus.data_out = load_q;
                TMR_COUNT:    bus.data_out = count_q;
                TMR_STATUS:   bus.data_out = {31'd0, expired_q};
                TMR_PRESCALE: bus.data_out = {16'd0, prescale_q};
                default:      bus.data_out = 32'd0;
            endcase
        end
    end

    assign bus.hit = hit;
    assign irq     = irq_q;

endmodule
